router_fsm: RTL and testbench

- Control state machine for the 1x3 router input path.
- Decodes the 2-bit destination address in the header byte and waits for the target FIFO to be free.
- Sequences the register/parity datapath via one-hot-style state strobes (detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg).
- Generates write_enb_reg for the FIFO bank and busy for the source.

---
 rtl/router_fsm.sv | 185 ++++++++++++++++++
 tb/tb_router_fsm.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/router_fsm.sv
// Control FSM for the 1x3 router input path: decodes the header address,
// waits for the target FIFO, and strobes the register/parity datapath.
module router_fsm (
    input  logic       clk,
    input  logic       rst,
    input  logic       pkt_valid,
    input  logic [1:0] data_in,
    input  logic       fifo_full,
    input  logic       fifo_empty_0,
    input  logic       fifo_empty_1,
    input  logic       fifo_empty_2,
    input  logic       soft_reset_0,
    input  logic       soft_reset_1,
    input  logic       soft_reset_2,
    input  logic       parity_done,
    input  logic       low_pkt_valid,
    output logic       write_enb_reg,
    output logic       detect_add,
    output logic       lfd_state,
    output logic       ld_state,
    output logic       laf_state,
    output logic       full_state,
    output logic       rst_int_reg,
    output logic       busy,
    output logic [1:0] addr_out
);

    typedef enum logic [2:0] {
        DECODE_ADDRESS     = 3'd0,
        LOAD_FIRST_DATA    = 3'd1,
        LOAD_DATA          = 3'd2,
        FIFO_FULL_STATE    = 3'd3,
        LOAD_AFTER_FULL    = 3'd4,
        LOAD_PARITY        = 3'd5,
        CHECK_PARITY_ERROR = 3'd6,
        WAIT_TILL_EMPTY    = 3'd7
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] addr_out_q, addr_out_d;
    logic       hdr_ok_s;
    logic       empty_hdr_s;
    logic       empty_addr_s;
    logic       soft_rst_s;

    // Per-port selects: header address for the decode cycle, latched address otherwise
    always_comb begin
        hdr_ok_s = pkt_valid && (data_in != 2'b11);
        case (data_in)
            2'b00:   empty_hdr_s = fifo_empty_0;
            2'b01:   empty_hdr_s = fifo_empty_1;
            2'b10:   empty_hdr_s = fifo_empty_2;
            default: empty_hdr_s = 1'b0;
        endcase
        case (addr_out_q)
            2'b00: begin
                empty_addr_s = fifo_empty_0;
                soft_rst_s   = soft_reset_0;
            end
            2'b01: begin
                empty_addr_s = fifo_empty_1;
                soft_rst_s   = soft_reset_1;
            end
            2'b10: begin
                empty_addr_s = fifo_empty_2;
                soft_rst_s   = soft_reset_2;
            end
            default: begin
                empty_addr_s = 1'b0;
                soft_rst_s   = 1'b0;
            end
        endcase
    end

    // Next-state and address-latch logic
    always_comb begin
        state_d    = state_q;
        addr_out_d = addr_out_q;
        if ((state_q == DECODE_ADDRESS) && hdr_ok_s) begin
            addr_out_d = data_in;
        end else begin
            addr_out_d = addr_out_q;
        end
        if (soft_rst_s) begin
            state_d = DECODE_ADDRESS;
        end else begin
            case (state_q)
                DECODE_ADDRESS: begin
                    if (hdr_ok_s) begin
                        state_d = empty_hdr_s ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
                    end else begin
                        state_d = DECODE_ADDRESS;
                    end
                end
                WAIT_TILL_EMPTY: begin
                    state_d = empty_addr_s ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
                end
                LOAD_FIRST_DATA: state_d = LOAD_DATA;
                LOAD_DATA: begin
                    // A full FIFO must be serviced before the parity byte is taken
                    if (fifo_full) begin
                        state_d = FIFO_FULL_STATE;
                    end else if (!pkt_valid) begin
                        state_d = LOAD_PARITY;
                    end else begin
                        state_d = LOAD_DATA;
                    end
                end
                FIFO_FULL_STATE: begin
                    state_d = fifo_full ? FIFO_FULL_STATE : LOAD_AFTER_FULL;
                end
                LOAD_AFTER_FULL: begin
                    if (parity_done) begin
                        state_d = DECODE_ADDRESS;
                    end else if (low_pkt_valid) begin
                        state_d = LOAD_PARITY;
                    end else begin
                        state_d = LOAD_DATA;
                    end
                end
                LOAD_PARITY: state_d = CHECK_PARITY_ERROR;
                CHECK_PARITY_ERROR: begin
                    state_d = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
                end
                default: state_d = DECODE_ADDRESS;
            endcase
        end
    end

    // State and address registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= DECODE_ADDRESS;
            addr_out_q <= 2'b00;
        end else begin
            state_q    <= state_d;
            addr_out_q <= addr_out_d;
        end
    end

    // Moore output decode from the current state only
    always_comb begin
        write_enb_reg = 1'b0;
        detect_add    = 1'b0;
        lfd_state     = 1'b0;
        ld_state      = 1'b0;
        laf_state     = 1'b0;
        full_state    = 1'b0;
        rst_int_reg   = 1'b0;
        busy          = 1'b0;
        case (state_q)
            DECODE_ADDRESS: detect_add = 1'b1;
            LOAD_FIRST_DATA: begin
                lfd_state = 1'b1;
                busy      = 1'b1;
            end
            LOAD_DATA: begin
                ld_state      = 1'b1;
                write_enb_reg = 1'b1;
            end
            FIFO_FULL_STATE: begin
                full_state = 1'b1;
                busy       = 1'b1;
            end
            LOAD_AFTER_FULL: begin
                laf_state     = 1'b1;
                write_enb_reg = 1'b1;
                busy          = 1'b1;
            end
            LOAD_PARITY: begin
                write_enb_reg = 1'b1;
                busy          = 1'b1;
            end
            CHECK_PARITY_ERROR: begin
                rst_int_reg = 1'b1;
                busy        = 1'b1;
            end
            WAIT_TILL_EMPTY: busy = 1'b1;
            default: detect_add = 1'b0;
        endcase
    end

    assign addr_out = addr_out_q;

endmodule

// File: tb/tb_router_fsm.sv
// Randomized bench for router_fsm against a behavioural packet-phase model.
module tb_router_fsm;

    logic       clk = 1'b0;
    logic       rst;
    logic       pkt_valid;
    logic [1:0] data_in;
    logic       fifo_full;
    logic       fifo_empty_0, fifo_empty_1, fifo_empty_2;
    logic       soft_reset_0, soft_reset_1, soft_reset_2;
    logic       parity_done, low_pkt_valid;
    logic       write_enb_reg, detect_add, lfd_state, ld_state, laf_state;
    logic       full_state, rst_int_reg, busy;
    logic [1:0] addr_out;

    int checks = 0;
    int errors = 0;

    // Model phases, named after what the router is doing with the packet
    localparam int PH_IDLE   = 100;
    localparam int PH_HDR    = 101;
    localparam int PH_BODY   = 102;
    localparam int PH_STALL  = 103;
    localparam int PH_RESUME = 104;
    localparam int PH_PAR    = 105;
    localparam int PH_CHK    = 106;
    localparam int PH_WAIT   = 107;

    int         m_phase;
    logic [1:0] m_addr;

    router_fsm dut (
        .clk(clk), .rst(rst), .pkt_valid(pkt_valid), .data_in(data_in),
        .fifo_full(fifo_full), .fifo_empty_0(fifo_empty_0),
        .fifo_empty_1(fifo_empty_1), .fifo_empty_2(fifo_empty_2),
        .soft_reset_0(soft_reset_0), .soft_reset_1(soft_reset_1),
        .soft_reset_2(soft_reset_2), .parity_done(parity_done),
        .low_pkt_valid(low_pkt_valid), .write_enb_reg(write_enb_reg),
        .detect_add(detect_add), .lfd_state(lfd_state), .ld_state(ld_state),
        .laf_state(laf_state), .full_state(full_state),
        .rst_int_reg(rst_int_reg), .busy(busy), .addr_out(addr_out)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [9:0] got, input logic [9:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b (phase %0d) at %0t", tag, got, exp, m_phase, $time);
        end
    endtask

    // Expected {wen, detect, lfd, ld, laf, full, rst_int, busy}
    function automatic logic [7:0] expect_outs(input int ph);
        case (ph)
            PH_IDLE:   return 8'b0100_0000;
            PH_HDR:    return 8'b0010_0001;
            PH_BODY:   return 8'b1001_0000;
            PH_STALL:  return 8'b0000_0101;
            PH_RESUME: return 8'b1000_1001;
            PH_PAR:    return 8'b1000_0001;
            PH_CHK:    return 8'b0000_0011;
            PH_WAIT:   return 8'b0000_0001;
            default:   return 8'hxx;
        endcase
    endfunction

    task automatic model_clock();
        logic [2:0] emp;
        logic [2:0] srs;
        logic [1:0] nxt_addr;
        emp = {fifo_empty_2, fifo_empty_1, fifo_empty_0};
        srs = {soft_reset_2, soft_reset_1, soft_reset_0};
        if (!rst) begin
            m_phase = PH_IDLE;
            m_addr  = 2'b00;
        end else begin
            nxt_addr = m_addr;
            if (m_phase == PH_IDLE && pkt_valid && data_in != 2'b11) nxt_addr = data_in;
            if (srs[m_addr]) m_phase = PH_IDLE;
            else if (m_phase == PH_IDLE) begin
                if (pkt_valid && data_in != 2'b11) m_phase = emp[data_in] ? PH_HDR : PH_WAIT;
            end
            else if (m_phase == PH_WAIT)   m_phase = emp[m_addr] ? PH_HDR : PH_WAIT;
            else if (m_phase == PH_HDR)    m_phase = PH_BODY;
            else if (m_phase == PH_BODY)   m_phase = fifo_full ? PH_STALL : (!pkt_valid ? PH_PAR : PH_BODY);
            else if (m_phase == PH_STALL)  m_phase = fifo_full ? PH_STALL : PH_RESUME;
            else if (m_phase == PH_RESUME) m_phase = parity_done ? PH_IDLE : (low_pkt_valid ? PH_PAR : PH_BODY);
            else if (m_phase == PH_PAR)    m_phase = PH_CHK;
            else if (m_phase == PH_CHK)    m_phase = fifo_full ? PH_STALL : PH_IDLE;
            m_addr = nxt_addr;
        end
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_clock();
        #1;
        check_eq(tag,
                 {write_enb_reg, detect_add, lfd_state, ld_state, laf_state,
                  full_state, rst_int_reg, busy, addr_out},
                 {expect_outs(m_phase), m_addr});
    endtask

    task automatic quiet();
        rst = 1'b1; pkt_valid = 1'b0; data_in = 2'b00; fifo_full = 1'b0;
        fifo_empty_0 = 1'b1; fifo_empty_1 = 1'b1; fifo_empty_2 = 1'b1;
        soft_reset_0 = 1'b0; soft_reset_1 = 1'b0; soft_reset_2 = 1'b0;
        parity_done = 1'b0; low_pkt_valid = 1'b0;
    endtask

    initial begin
        quiet();
        m_phase = PH_IDLE;
        m_addr  = 2'b00;
        rst = 1'b0;
        step("reset");
        step("reset_hold");
        rst = 1'b1;
        step("idle");

        // Header to port 1, four payload bytes, then parity
        pkt_valid = 1'b1; data_in = 2'b01;
        step("hdr01");
        data_in = 2'b10; fifo_empty_1 = 1'b0;
        repeat (4) step("payload");
        pkt_valid = 1'b0;
        step("parity");
        step("check_par");
        step("back_idle");

        // Full stall during body, resume to body
        pkt_valid = 1'b1; data_in = 2'b00;
        step("hdr00");
        step("body");
        fifo_full = 1'b1;
        repeat (3) step("full");
        fifo_full = 1'b0;
        step("resume");
        step("back_body");
        soft_reset_1 = 1'b1;
        step("sr_other_port");
        soft_reset_1 = 1'b0; soft_reset_0 = 1'b1;
        step("sr_own_port");
        soft_reset_0 = 1'b0;

        // Busy destination, invalid address, reset while stalled
        data_in = 2'b10; fifo_empty_2 = 1'b0;
        step("hdr10_busy");
        repeat (2) step("wait_empty");
        fifo_empty_2 = 1'b1;
        step("empty_rise");
        data_in = 2'b11;
        step("body2");
        fifo_full = 1'b1;
        step("full2");
        rst = 1'b0;
        step("rst_in_full");
        rst = 1'b1; fifo_full = 1'b0;
        step("hdr11_drop");
        step("hdr11_drop2");

        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            rst           = ($urandom_range(199, 0) != 0);
            pkt_valid     = ($urandom_range(3, 0) != 0);
            data_in       = 2'($urandom_range(3, 0));
            fifo_full     = ($urandom_range(4, 0) == 0);
            fifo_empty_0  = ($urandom_range(2, 0) != 0);
            fifo_empty_1  = ($urandom_range(2, 0) != 0);
            fifo_empty_2  = ($urandom_range(2, 0) != 0);
            soft_reset_0  = ($urandom_range(39, 0) == 0);
            soft_reset_1  = ($urandom_range(39, 0) == 0);
            soft_reset_2  = ($urandom_range(39, 0) == 0);
            parity_done   = ($urandom_range(3, 0) == 0);
            low_pkt_valid = ($urandom_range(1, 0) == 0);
            step("random");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
